// File: rtl/hdb3_pkg.sv
// Shared HDB3 symbol codes and defaults for the inserter, polarity stage and decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdb3_pkg;

   typedef logic [1:0] sym_t;

   localparam sym_t SYM_ZERO = 2'b00;
   localparam sym_t SYM_ONE  = 2'b01;
   localparam sym_t SYM_B    = 2'b10;
   localparam sym_t SYM_V    = 2'b11;

   // Zero-run length that triggers substitution; 4 gives HDB3.
   localparam int RUN_LEN_DEF = 4;

endpackage

// File: rtl/hdb3_sym_buf.sv
// DEPTH x 2-bit symbol shift buffer with a write-back port on its tail stage.
// Latency: a symbol shifted in on enable k is presented on dout after enable k+DEPTH.
// Backpressure: none; shifts only when en=1, holds otherwise, clr wins over en.
module hdb3_sym_buf
   import hdb3_pkg::*;
#(
   parameter int DEPTH = RUN_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  sym_t din,
   input  logic wb_en,
   input  sym_t wb_dat,
   output sym_t dout
);

   sym_t s [DEPTH];

   // Shift chain: s[0] takes the new symbol, tail stage may be overwritten by write-back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) s[i] <= SYM_ZERO;
         dout <= SYM_ZERO;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) s[i] <= SYM_ZERO;
         dout <= SYM_ZERO;
      end else if (en) begin
         dout <= s[DEPTH-1];
         s[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            if (i == DEPTH-1 && wb_en) s[i] <= wb_dat;
            else                       s[i] <= s[i-1];
         end
      end
   end

endmodule

// File: rtl/hdb3_vb_insert.sv
// HDB3 front end: finds RUN_LEN-zero runs and schedules V/B symbols into them.
// Latency: bit sampled on enable k appears on code_out after enable k+RUN_LEN.
// Backpressure: none; all state advances only on en=1, clr acts regardless of en.
module hdb3_vb_insert
   import hdb3_pkg::*;
#(
   parameter int RUN_LEN = RUN_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic       data_in,
   output logic [1:0] code_out,
   output logic       out_valid,
   output logic       sub_v,
   output logic       sub_b
);

   localparam int ZW = $clog2(RUN_LEN);
   localparam int FW = $clog2(RUN_LEN + 1);

   logic [ZW-1:0] zcnt;
   logic          par;
   logic [FW-1:0] fill;
   logic          run_done;
   logic          ins_b;
   sym_t          new_sym;

   // Classify the incoming bit: mark, ordinary zero, or the zero completing a run.
   always_comb begin
      run_done = 1'b0;
      new_sym  = SYM_ZERO;
      if (data_in) begin
         new_sym = SYM_ONE;
      end else if (zcnt == ZW'(RUN_LEN - 1)) begin
         run_done = 1'b1;
         new_sym  = SYM_V;
      end
   end

   // A B is needed only when the marks since the last V are even.
   assign ins_b = run_done && !par;

   // Zero counter, mark parity, fill level and the substitution strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         zcnt      <= '0;
         par       <= 1'b0;
         fill      <= '0;
         out_valid <= 1'b0;
         sub_v     <= 1'b0;
         sub_b     <= 1'b0;
      end else if (clr) begin
         zcnt      <= '0;
         par       <= 1'b0;
         fill      <= '0;
         out_valid <= 1'b0;
         sub_v     <= 1'b0;
         sub_b     <= 1'b0;
      end else if (en) begin
         out_valid <= (fill == FW'(RUN_LEN));
         if (fill != FW'(RUN_LEN)) fill <= fill + 1'b1;
         sub_v <= run_done;
         sub_b <= ins_b;
         if (data_in) begin
            zcnt <= '0;
            par  <= ~par;
         end else if (run_done) begin
            zcnt <= '0;
            par  <= 1'b0;
         end else begin
            zcnt <= zcnt + 1'b1;
         end
      end
   end

   hdb3_sym_buf #(
      .DEPTH (RUN_LEN)
   ) u_buf (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (en),
      .din    (new_sym),
      .wb_en  (ins_b),
      .wb_dat (SYM_B),
      .dout   (code_out)
   );

endmodule

// File: doc/hdb3_vb_insert.md
Name: hdb3_vb_insert

Overview:
- Front-end sequencer of the HDB3 encoder.
- Takes the raw NRZ bit stream and finds every run of RUN_LEN consecutive zeros.
- Schedules violation (V) and bipolar-balance (B) pulses into that run.
- Emits the 2-bit symbol codes consumed by the polarity stage: 00 = zero, 01 = mark, 10 = B, 11 = V.
- Holds a RUN_LEN-deep look-behind buffer so a B can be written back into the first zero of a run.

Parameters:
- RUN_LEN, default 4: zero-run length that triggers substitution. 4 gives HDB3. Legal range is 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  bit strobe. All state advances only on clk edges with en=1.
- clr  in  1  synchronous clear of buffer, counters and parity. Takes effect regardless of en.
- data_in  in  1  NRZ input bit, sampled when en=1.
- code_out  out  2  symbol code to the polarity stage (00/01/10/11 as above).
- out_valid  out  1  code_out carries a real symbol. Low while the buffer fills.
- sub_v  out  1  one-enable pulse: a V was inserted at the buffer head this enable.
- sub_b  out  1  one-enable pulse: a B was also written into the run's first zero this enable.

Behaviour:

Reset (rst=0) and clr=1:
- Buffer stages s[0..RUN_LEN-1] = 00, code_out = 00.
- zcnt = 0, par = 0 (even), fill = 0.
- out_valid = 0, sub_v = 0, sub_b = 0.
- clr has priority over en.

en=0:
- All registers hold.
- sub_v and sub_b also hold; they are qualified by en downstream.

On each edge with en=1, all next-state values are computed from the pre-edge state:
- Buffer shift: code_out <= s[RUN_LEN-1]; s[i] <= s[i-1]; s[0] <= new code.
- Latency: a bit sampled at enable k appears on code_out after enable k+RUN_LEN.

data_in=1:
- New code = 01.
- par toggles.
- zcnt <= 0.

data_in=0 and zcnt < RUN_LEN-1:
- New code = 00.
- zcnt <= zcnt+1.

data_in=0 and zcnt = RUN_LEN-1 (run complete):
- s[0] <= 11 (V), sub_v = 1.
- If par = 0, s[RUN_LEN-1] <= 10 (B), overriding the shifted-in 00, and sub_b = 1.
- If par = 1, s[RUN_LEN-1] takes the shifted 00 as normal.
- zcnt <= 0 and par <= 0.
- A B is always followed by its V, so parity after a V is always even.

Other rules:
- Runs longer than RUN_LEN: a new substitution starts after every RUN_LEN zeros. There is no overlap between runs.
- fill saturates at RUN_LEN. On en, out_valid <= (fill == RUN_LEN), evaluated before fill increments. out_valid therefore first rises on the (RUN_LEN+1)th enable.
- Reset mid-stream: buffered symbols are discarded, not flushed, and out_valid drops at once. Downstream polarity restarts from its own reset.
- Width rules: zcnt is $clog2(RUN_LEN) bits and par is 1 bit. No arithmetic overflow is possible.

Decomposition:
- Shared package hdb3_pkg holds:
  - constants SYM_ZERO=2'b00, SYM_ONE=2'b01, SYM_B=2'b10, SYM_V=2'b11;
  - the RUN_LEN default.
- The same package is used by the polarity stage and the decoder.
- One sub-module is natural: hdb3_sym_buf, a RUN_LEN x 2-bit shift buffer with a write-back port on its tail stage.
- zcnt, parity and fill logic stay in the top module.

Test Plan:
- Reset, en=1 every cycle, data 0,0,0,0, then 1s. Expected: code_out from the 5th enable = 10,00,00,11,01…; sub_b and sub_v both pulse on the 4th enable.
- Data 1,0,0,0,0. Expected: 01,00,00,00,11; sub_v=1 and sub_b=0, because parity was odd.
- Data 1,1,0,0,0,0. Expected: 01,01,10,00,00,11.
- Eight zeros after reset. Expected: 10,00,00,11,10,00,00,11; two sub_v pulses, 4 enables apart.
- en toggling 1-0-1 with data 0,0,0,0 spread over 8 clocks. Expected: same output as the first test, code_out stable during en=0, out_valid low until the 5th enable.
- Assert rst after 0,0,0 mid-run, then release and feed 0. Expected: all outputs 00/0 immediately; the new 0 counts as zcnt=1, and a B is still inserted since par resets to 0.
